deadtime_monitor: RTL
=====================

# deadtime_monitor

Independent check on the complementary gate pair driven by the dead-time inserter, sitting between that stage and the gate-driver pins. Measures every dead interval in MClk cycles, flags shoot-through (both gates high) and dead times shorter than a programmed minimum, and latches a fault that forces both gate outputs low until software clears it.

## Interface
- BIT_WIDTH, 16, width of the dead-time threshold, the interval counter and the measurement output
- MClk  input  1  system clock; all state on rising edge
- RstN  input  1  reset, asynchronous, active-low
- MinDeadCount  input  BIT_WIDTH  minimum legal dead time in MClk cycles; 0 disables the short-dead check
- S  input  2  gate pair from dead-time inserter; S[0] high-side, S[1] low-side
- FaultClr  input  1  level request to clear a latched fault
- SOut  output  2  gated gate pair to drivers
- Fault  output  1  latched fault flag
- FaultCode  output  2  01 overlap, 10 short dead time, 00 none; latched with Fault
- MeasDead  output  BIT_WIDTH  last measured dead interval (cycles S was 00 before a switchover)
- MeasValid  output  1  one-cycle pulse when MeasDead updates

## Operation
- States: IDLE (no prior active side), DEAD (S==00 after a side was active; counting), ON_H (S==01), ON_L (S==10), FAULT.
- Interval counter: cleared on entry to DEAD, +1 per cycle while S==00, saturates at all-ones (no wrap).
- IDLE: S==01 -> ON_H, S==10 -> ON_L; no measurement, no short check.
- ON_H/ON_L: S==00 -> DEAD (count starts at 1 for the first 00 cycle); S==same side -> stay; direct switch to other side -> interval 0, apply switchover check.
- DEAD, S becomes one-hot: if new side differs from previous side -> MeasDead <= count, MeasValid pulse, short fault if MinDeadCount != 0 and count < MinDeadCount; if same side (skipped pulse) -> no measurement, no check. Go to ON_H/ON_L.
- S==11 in any non-FAULT state -> FAULT, FaultCode 01.
- Priority: overlap (01) over short (10); only the first fault is latched, later violations do not change FaultCode.
- FAULT: SOut held 00. Exit to IDLE only when FaultClr==1 and S==00 in the same cycle; Fault and FaultCode clear on that edge. Violation detected in the clearing cycle is impossible (S==00), so clear always wins when accepted; FaultClr with S!=00 is ignored.
- SOut = registered S when no fault is being entered or held, else 00.

## Timing
- Reset (async): state IDLE, counter 0, SOut 00, Fault 0, FaultCode 00, MeasDead 0, MeasValid 0.
- SOut latency 1 cycle from S.
- Fault and FaultCode assert on the edge that samples the violating S; SOut on that same edge is 00 (no violating value ever reaches SOut).
- MeasValid and MeasDead update on the edge that samples the new one-hot S; MeasValid low the next cycle unless another switchover.
- MinDeadCount sampled at the switchover edge; changes mid-interval apply to the current interval.
- Reset asserted mid-interval or in FAULT: immediate return to reset values; next activation treated as first (IDLE).

## Structure
- Shared package pwm_pkg: state enum (IDLE, DEAD, ON_H, ON_L, FAULT), fault-code constants FC_NONE=00, FC_OVERLAP=01, FC_SHORT=10, gate-pair encodings GATE_OFF=00, GATE_H=01, GATE_L=10.
- One sub-module sat_counter (BIT_WIDTH, clear, enable, saturating count out); FSM, fault latch and output gating in the top.

## Test plan
- Reset, S=01 x5, 00 x4, 10 -> MeasValid pulse, MeasDead=4, Fault=0, SOut follows S with 1-cycle lag.
- MinDeadCount=5, S: 01, 00 x3, 10 -> Fault=1, FaultCode=10, SOut=00 from that edge, MeasDead=3.
- S=11 for one cycle in ON_L -> Fault=1, FaultCode=01, SOut never 11; later short interval leaves FaultCode=01.
- In FAULT, FaultClr=1 with S=10 -> stays faulted; FaultClr=1 with S=00 -> Fault=0, state IDLE; next S=01 gives no MeasValid.
- MinDeadCount=0, S: 01 directly to 10 -> MeasDead=0, MeasValid pulse, no fault; S: 01, 00 x2, 01 -> no MeasValid.
- BIT_WIDTH=4, S=00 for 20 cycles between sides -> MeasDead=15 (saturated); RstN low mid-interval -> all outputs 0 immediately.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared encodings for the PWM gate path: monitor states, fault codes and
// gate-pair patterns.
package pwm_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DEAD  = 3'd1,
    ON_H  = 3'd2,
    ON_L  = 3'd3,
    FAULT = 3'd4
  } state_t;

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_OVERLAP = 2'b01;
  localparam logic [1:0] FC_SHORT   = 2'b10;

  localparam logic [1:0] GATE_OFF  = 2'b00;
  localparam logic [1:0] GATE_H    = 2'b01;
  localparam logic [1:0] GATE_L    = 2'b10;
  localparam logic [1:0] GATE_BOTH = 2'b11;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter. Clear restarts from zero, and when Enable is also
// high the cleared value already includes that cycle (loads 1).
module sat_counter #(
  parameter int BIT_WIDTH = 16
) (
  input  logic                 MClk,
  input  logic                 RstN,
  input  logic                 Clear,
  input  logic                 Enable,
  output logic [BIT_WIDTH-1:0] Count
);

  always_ff @(posedge MClk or negedge RstN) begin
    if (!RstN) begin
      Count <= '0;
    end else if (Clear) begin
      Count <= {{(BIT_WIDTH-1){1'b0}}, Enable};
    end else if (Enable && (Count != {BIT_WIDTH{1'b1}})) begin
      Count <= Count + BIT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/deadtime_monitor.sv
// Dead-time monitor: measures each 00 gap between opposite gate pulses,
// latches overlap / short-dead faults and blanks the gate pair while faulted.
module deadtime_monitor
  import pwm_pkg::*;
#(
  parameter int BIT_WIDTH = 16
) (
  input  logic                 MClk,
  input  logic                 RstN,
  input  logic [BIT_WIDTH-1:0] MinDeadCount,
  input  logic [1:0]           S,
  input  logic                 FaultClr,
  output logic [1:0]           SOut,
  output logic                 Fault,
  output logic [1:0]           FaultCode,
  output logic [BIT_WIDTH-1:0] MeasDead,
  output logic                 MeasValid,
  output logic [2:0]           DbgState
);

  state_t               state;
  logic                 last_high;
  logic                 cnt_clr;
  logic                 cnt_en;
  logic [BIT_WIDTH-1:0] cnt;
  logic                 s_high;
  logic                 prev_high;
  logic                 switchover;
  logic [BIT_WIDTH-1:0] interval;
  logic                 short_hit;

  assign DbgState = state;

  // Counter only runs through a dead gap; any other state holds it at zero.
  assign cnt_clr = (state != DEAD);
  assign cnt_en  = (S == GATE_OFF) &&
                   ((state == DEAD) || (state == ON_H) || (state == ON_L));

  sat_counter #(.BIT_WIDTH(BIT_WIDTH)) u_cnt (
    .MClk   (MClk),
    .RstN   (RstN),
    .Clear  (cnt_clr),
    .Enable (cnt_en),
    .Count  (cnt)
  );

  always_comb begin
    s_high     = (S == GATE_H);
    prev_high  = (state == DEAD) ? last_high : (state == ON_H);
    switchover = (state != IDLE) && (state != FAULT) &&
                 ((S == GATE_H) || (S == GATE_L)) && (s_high != prev_high);
    interval   = (state == DEAD) ? cnt : '0;
    short_hit  = (MinDeadCount != '0) && (interval < MinDeadCount);
  end

  always_ff @(posedge MClk or negedge RstN) begin
    if (!RstN) begin
      state     <= IDLE;
      last_high <= 1'b0;
      SOut      <= GATE_OFF;
      Fault     <= 1'b0;
      FaultCode <= FC_NONE;
      MeasDead  <= '0;
      MeasValid <= 1'b0;
    end else begin
      MeasValid <= 1'b0;
      if (state == FAULT) begin
        SOut <= GATE_OFF;
        if (FaultClr && (S == GATE_OFF)) begin
          state     <= IDLE;
          Fault     <= 1'b0;
          FaultCode <= FC_NONE;
        end
      end else if (S == GATE_BOTH) begin
        state     <= FAULT;
        Fault     <= 1'b1;
        FaultCode <= FC_OVERLAP;
        SOut      <= GATE_OFF;
      end else if (S == GATE_OFF) begin
        SOut <= GATE_OFF;
        if ((state == ON_H) || (state == ON_L)) begin
          state     <= DEAD;
          last_high <= (state == ON_H);
        end
      end else if (switchover && short_hit) begin
        MeasDead  <= interval;
        MeasValid <= 1'b1;
        state     <= FAULT;
        Fault     <= 1'b1;
        FaultCode <= FC_SHORT;
        SOut      <= GATE_OFF;
      end else begin
        // Legal one-hot: plain activation, skipped pulse, or good switchover.
        if (switchover) begin
          MeasDead  <= interval;
          MeasValid <= 1'b1;
        end
        state <= s_high ? ON_H : ON_L;
        SOut  <= S;
      end
    end
  end

endmodule
